// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder
//   Registered RV32I decode/issue stage. Turns an instruction word into the
//   ALU op code, operand selects, immediate and register indices, with
//   valid/ready handshakes on both sides and one cycle of latency.
//
//   Ports:
//     clk, rst                 clock (rising edge), synchronous active-high reset
//     in_valid/in_ready        upstream handshake
//     in_instr, in_pc          instruction word and its address
//     out_valid/out_ready      downstream handshake
//     out_alu_op               4-bit ALU operation code
//     out_a_sel                0 = rs1, 1 = pc
//     out_b_sel                0 = rs2, 1 = imm
//     out_imm                  decoded immediate
//     out_rs1/out_rs2/out_rd   register indices
//     out_reg_we               register write enable (never set for rd = x0)
//     out_illegal              unsupported or malformed instruction
//     out_pc                   in_pc passed through
//
//   Build option: define ALU_ISSUE_SKID_EN for a two-entry (output + skid)
//   buffer with a registered in_ready; otherwise a single output register
//   with in_ready = out_ready | !out_valid.

module alu_issue_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic        out_a_sel,
    output logic        out_b_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_reg_we,
    output logic        out_illegal,
    output logic [31:0] out_pc
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011
    } opcode_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    bundle_t     dec;
    bundle_t     out_q;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        legal;
    logic        is_shift;

    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u  = {in_instr[31:12], 12'b0};

    // ALU codes are {alt, funct3}: alt selects sub/sra over add/srl.
    always_comb begin
        dec         = '0;
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.pc      = in_pc;
        legal       = 1'b1;
        is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);

        case (opcode_t'(in_instr[6:0]))
            OPC_OP: begin
                dec.alu_op = {funct7[5], funct3};
                dec.reg_we = 1'b1;
                legal      = (funct7 == 7'b0000000) ||
                             ((funct7 == 7'b0100000) &&
                              ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec.b_sel  = 1'b1;
                dec.reg_we = 1'b1;
                if (is_shift) begin
                    dec.alu_op = {funct7[5] & (funct3 == 3'b101), funct3};
                    dec.imm    = {27'b0, in_instr[24:20]};
                    legal      = (funct7 == 7'b0000000) ||
                                 ((funct7 == 7'b0100000) && (funct3 == 3'b101));
                end else begin
                    dec.alu_op = {1'b0, funct3};
                    dec.imm    = imm_i;
                end
            end
            OPC_LUI: begin
                dec.alu_op = 4'b1001;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec.reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel  = 1'b1;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec.reg_we = 1'b1;
            end
            OPC_LOAD: begin
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                dec.reg_we = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel  = 1'b1;
                dec.imm    = imm_s;
            end
            default: legal = 1'b0;
        endcase

        if (in_instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end

        // Illegal bundles still issue, but with a neutral datapath setup.
        if (!legal) begin
            dec.alu_op  = '0;
            dec.a_sel   = 1'b0;
            dec.b_sel   = 1'b0;
            dec.imm     = '0;
            dec.reg_we  = 1'b0;
            dec.illegal = 1'b1;
        end

        if (dec.rd == 5'd0) begin
            dec.reg_we = 1'b0;
        end
    end

`ifdef ALU_ISSUE_SKID_EN
    bundle_t skid_q;
    logic    skid_valid;
    logic    rdy_q;

    // rdy_q mirrors !skid_valid; rst gating keeps in_ready low while in reset.
    assign in_ready = rdy_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            out_valid  <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            rdy_q      <= 1'b1;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_q      <= skid_q;
                skid_valid <= 1'b0;
                rdy_q      <= 1'b1;
            end
        end else if (in_valid && in_ready) begin
            if (!out_valid || out_ready) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
                rdy_q      <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = ~rst & (out_ready | ~out_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_q     <= dec;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign out_alu_op  = out_q.alu_op;
    assign out_a_sel   = out_q.a_sel;
    assign out_b_sel   = out_q.b_sel;
    assign out_imm     = out_q.imm;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_reg_we  = out_q.reg_we;
    assign out_illegal = out_q.illegal;
    assign out_pc      = out_q.pc;

endmodule
